// File: rtl/n_bit_reg_file.sv
// Register file with a two-entry in-order write queue.
// Reads forward from the newest matching queued write; register 0 reads zero.
module n_bit_reg_file #(
  parameter int Nsize = 8,
  parameter int Asize = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [Asize-1:0] wr_addr,
  input  logic [Nsize-1:0] wr_data,
  input  logic             commit_en,
  input  logic [Asize-1:0] rd_addr_a,
  input  logic [Asize-1:0] rd_addr_b,
  output logic [Nsize-1:0] rd_data_a,
  output logic [Nsize-1:0] rd_data_b,
  output logic [1:0]       pending
);

  localparam int Depth = 2 ** Asize;

  logic [Nsize-1:0] mem    [Depth];
  logic [Asize-1:0] q_addr [2];
  logic [Nsize-1:0] q_data [2];
  logic [1:0]       count;

  logic [Asize-1:0] n_addr [2];
  logic [Nsize-1:0] n_data [2];
  logic [1:0]       n_count;
  logic             accept;
  logic             retire;
  logic             tail;

  assign wr_ready = (count != 2'd2);
  assign pending  = count;
  assign accept   = wr_valid && wr_ready;
  assign retire   = commit_en && (count != 2'd0);
  // slot 0 is the head; a same-edge retire shifts first, then appends
  assign tail     = retire ? 1'b0 : count[0];

  always_comb begin
    n_addr  = q_addr;
    n_data  = q_data;
    n_count = count + {1'b0, accept} - {1'b0, retire};
    if (retire) begin
      n_addr[0] = q_addr[1];
      n_data[0] = q_data[1];
    end
    if (accept) begin
      n_addr[tail] = wr_addr;
      n_data[tail] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      for (int i = 0; i < Depth; i++)
        mem[i] <= '0;
      for (int j = 0; j < 2; j++) begin
        q_addr[j] <= '0;
        q_data[j] <= '0;
      end
    end else begin
      count  <= n_count;
      q_addr <= n_addr;
      q_data <= n_data;
      if (retire && (q_addr[0] != '0))
        mem[q_addr[0]] <= q_data[0];
    end
  end

  function automatic logic [Nsize-1:0] rd_val(
    input logic [Asize-1:0] a
  );
    if (a == '0)
      return '0;
    else if ((count == 2'd2) && (q_addr[1] == a))
      return q_data[1];
    else if ((count != 2'd0) && (q_addr[0] == a))
      return q_data[0];
    else
      return mem[a];
  endfunction

  always_comb begin
    rd_data_a = rd_val(rd_addr_a);
    rd_data_b = rd_val(rd_addr_b);
  end

endmodule

// File: tb/tb_n_bit_reg_file.sv
// Bench for n_bit_reg_file: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_n_bit_reg_file;

  logic       clk;
  logic       reset_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit_en;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic [1:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       mq [$];
  logic [7:0] mm [8];

  logic [7:0] obs_a, obs_b;
  logic [1:0] obs_p;
  logic       obs_r;

  n_bit_reg_file #(.Nsize(8), .Asize(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_en(commit_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return mq[i].d;
    return mm[a];
  endfunction

  task automatic m_clear();
    mq.delete();
    for (int i = 0; i < 8; i++) mm[i] = 8'h00;
  endtask

  task automatic step(input logic wv, input logic [2:0] wa,
                      input logic [7:0] wd, input logic ce,
                      input logic [2:0] ra, input logic [2:0] rb);
    bit rdy;
    ent_t e;
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    commit_en = ce; rd_addr_a = ra; rd_addr_b = rb;
    #1;
    obs_a = rd_data_a; obs_b = rd_data_b;
    obs_p = pending;   obs_r = wr_ready;
    chk("rd_a", {24'd0, obs_a}, {24'd0, m_rd(ra)});
    chk("rd_b", {24'd0, obs_b}, {24'd0, m_rd(rb)});
    chk("pending", {30'd0, obs_p}, mq.size());
    chk("wr_ready", {31'd0, obs_r}, {31'd0, mq.size() < 2});
    @(posedge clk);
    rdy = mq.size() < 2;
    if (ce && mq.size() > 0) begin
      e = mq.pop_front();
      if (e.a != 3'd0) mm[e.a] = e.d;
    end
    if (wv && rdy) begin
      e.a = wa; e.d = wd;
      mq.push_back(e);
    end
  endtask

  initial begin
    wr_valid = 0; wr_addr = 0; wr_data = 0; commit_en = 0;
    rd_addr_a = 3; rd_addr_b = 7;
    reset_n = 0;
    m_clear();
    #3;
    chk("rst_pending", {30'd0, pending}, 0);
    chk("rst_ready", {31'd0, wr_ready}, 1);
    chk("rst_rd_a", {24'd0, rd_data_a}, 0);
    chk("rst_rd_b", {24'd0, rd_data_b}, 0);
    @(negedge clk);
    reset_n = 1;

    // write with commit enabled
    step(1, 3, 8'h5A, 1, 0, 0);
    step(0, 0, 8'h00, 1, 3, 3);
    chk("w1_rd", {24'd0, obs_a}, 32'h5A);
    chk("w1_pend", {30'd0, obs_p}, 1);
    step(0, 0, 8'h00, 1, 3, 3);
    chk("w1_rd2", {24'd0, obs_a}, 32'h5A);
    chk("w1_pend2", {30'd0, obs_p}, 0);

    // fill queue, third write ignored
    step(1, 2, 8'h11, 0, 2, 5);
    step(1, 2, 8'h22, 0, 2, 5);
    step(1, 5, 8'h33, 0, 2, 5);
    chk("fill_pend", {30'd0, obs_p}, 2);
    chk("fill_ready", {31'd0, obs_r}, 0);
    chk("fill_rd", {24'd0, obs_a}, 32'h22);
    step(0, 0, 8'h00, 1, 2, 5);
    step(0, 0, 8'h00, 1, 2, 5);
    step(0, 0, 8'h00, 0, 2, 5);
    chk("fill_r2", {24'd0, obs_a}, 32'h22);
    chk("fill_r5", {24'd0, obs_b}, 0);
    chk("fill_pend0", {30'd0, obs_p}, 0);

    // sustained throughput, same-edge accept and retire
    step(1, 1, 8'h01, 1, 1, 0);
    step(1, 1, 8'h02, 1, 1, 0);
    chk("bb_pend1", {30'd0, obs_p}, 1);
    step(1, 1, 8'h03, 1, 1, 0);
    chk("bb_pend2", {30'd0, obs_p}, 1);
    step(1, 1, 8'h04, 1, 1, 0);
    chk("bb_rd3", {24'd0, obs_a}, 32'h03);
    step(0, 0, 8'h00, 1, 1, 0);
    chk("bb_rd4", {24'd0, obs_a}, 32'h04);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("bb_final", {24'd0, obs_a}, 32'h04);
    chk("bb_pend0", {30'd0, obs_p}, 0);

    // zero register
    step(1, 0, 8'hFF, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    chk("z_rd", {24'd0, obs_a}, 0);
    chk("z_pend1", {30'd0, obs_p}, 1);
    step(0, 0, 8'h00, 0, 0, 0);
    chk("z_rd2", {24'd0, obs_b}, 0);
    chk("z_pend0", {30'd0, obs_p}, 0);

    // dual read ports
    step(1, 4, 8'hA5, 1, 0, 0);
    step(1, 6, 8'h3C, 1, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 4, 6);
    chk("dp_a", {24'd0, obs_a}, 32'hA5);
    chk("dp_b", {24'd0, obs_b}, 32'h3C);
    step(0, 0, 8'h00, 0, 6, 6);
    chk("dp_aa", {24'd0, obs_a}, 32'h3C);
    chk("dp_bb", {24'd0, obs_b}, 32'h3C);

    // reset pulse with a full queue
    step(1, 1, 8'h77, 0, 1, 2);
    step(1, 2, 8'h88, 0, 1, 2);
    step(0, 0, 8'h00, 0, 1, 2);
    chk("mr_pend2", {30'd0, obs_p}, 2);
    @(negedge clk);
    wr_valid = 0; commit_en = 0;
    rd_addr_a = 1; rd_addr_b = 4;
    #2 reset_n = 0;
    #1;
    chk("mr_pend", {30'd0, pending}, 0);
    chk("mr_ready", {31'd0, wr_ready}, 1);
    chk("mr_rd_a", {24'd0, rd_data_a}, 0);
    chk("mr_rd_b", {24'd0, rd_data_b}, 0);
    m_clear();
    #1 reset_n = 1;
    step(0, 0, 8'h00, 1, 1, 2);
    step(0, 0, 8'h00, 0, 1, 2);
    chk("mr_after_a", {24'd0, obs_a}, 0);
    chk("mr_after_b", {24'd0, obs_b}, 0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 2) != 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
